// File: rtl/tcp_option_sequencer_if.sv
// ============================================================================
// Module   : tcp_option_sequencer_if
// Purpose  : Bundles the option-area word stream and the option-parser link
//            of tcp_option_sequencer into one interface.
// Signals  : in_valid/in_data/in_ready  - option-area word stream (byte 0 is
//                                         [31:24]), accepted on valid&ready
//            opt_rst/opt_vld/opt_pos/opt_data - per-option drive to parser
//            opt_av_in/opt_err_in        - parser option_av / option_err
// Modports : master - the sequencer; slave - stream source plus parser side
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tcp_option_sequencer_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        opt_rst;
  logic        opt_vld;
  logic [2:0]  opt_pos;
  logic [31:0] opt_data;
  logic [8:0]  opt_av_in;
  logic [8:0]  opt_err_in;

  modport master (
    input  in_valid, in_data, opt_av_in, opt_err_in,
    output in_ready, opt_rst, opt_vld, opt_pos, opt_data
  );

  modport slave (
    output in_valid, in_data, opt_av_in, opt_err_in,
    input  in_ready, opt_rst, opt_vld, opt_pos, opt_data
  );
endinterface

`default_nettype wire

// File: rtl/tcp_option_sequencer.sv
// ============================================================================
// Module   : tcp_option_sequencer
// Purpose  : Walks the TCP option area word by word and drives the option
//            field parser one option at a time: locates each option start,
//            pulses the parser reset, feeds the first word plus continuation
//            words, skips NOP, stops at EOL and drains unused words.
// Ports    : clk, reset (async, active low)
//            start/data_off - begin a new option area of 4*(data_off-5) bytes
//            bus            - word stream + parser link (master modport)
//            busy, done     - activity flag and one-cycle completion pulse
//            err, err_code  - sticky error, 1 len, 2 overrun, 3 parser,
//                             4 bad data_off
//            opts_av        - OR of parser option_av over all options
//            nop_cnt, opt_cnt (TCP_OPT_SEQ_STATS_EN only) - saturating counts
//            of NOPs skipped and options dispatched
// Options  : `define TCP_OPT_SEQ_STATS_EN adds the statistics counters
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcp_option_sequencer #(
  parameter int MAX_WORDS = 10,
  parameter int CURSOR_W  = 6
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               start,
  input  wire logic [3:0]         data_off,
  tcp_option_sequencer_if.master  bus,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [2:0]              err_code,
  output logic [8:0]              opts_av
`ifdef TCP_OPT_SEQ_STATS_EN
  ,
  output logic [5:0]              nop_cnt,
  output logic [3:0]              opt_cnt
`endif
);

  localparam int WIDX_W = $clog2(MAX_WORDS + 1);
  localparam int SUM_W  = ((CURSOR_W > 8) ? CURSOR_W : 8) + 1;

  localparam logic [2:0] c_err_none = 3'd0;
  localparam logic [2:0] c_err_len  = 3'd1;
  localparam logic [2:0] c_err_ovr  = 3'd2;
  localparam logic [2:0] c_err_par  = 3'd3;
  localparam logic [2:0] c_err_doff = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_GETLEN = 4'd3,
    S_PRST   = 4'd4,
    S_FEED   = 4'd5,
    S_CONT   = 4'd6,
    S_EVAL   = 4'd7,
    S_DRAIN  = 4'd8,
    S_DONE   = 4'd9
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [31:0]         r_word, w_word_nxt;       // word holding the cursor
  logic [31:0]         r_next, w_next_nxt;       // word prefetched for a length byte
  logic                r_have_next, w_have_next_nxt;
  logic [WIDX_W-1:0]   r_widx, w_widx_nxt;       // words accepted so far
  logic [WIDX_W-1:0]   r_area_words, w_area_words_nxt;
  logic [CURSOR_W-1:0] r_area_bytes, w_area_bytes_nxt;
  logic [CURSOR_W-1:0] r_cursor, w_cursor_nxt;   // byte offset of current option
  logic [1:0]          r_pos, w_pos_nxt;
  logic [7:0]          r_len, w_len_nxt;
  logic [WIDX_W-1:0]   r_rem, w_rem_nxt;         // continuation words still to feed
  logic                r_err, w_err_nxt;
  logic [2:0]          r_err_code, w_err_code_nxt;
  logic [8:0]          r_opts_av, w_opts_av_nxt;

  logic                w_in_ready, w_opt_rst, w_opt_vld;
  logic [1:0]          w_opt_pos;
  logic [31:0]         w_opt_data;

  logic [1:0]          w_pos;
  logic [7:0]          w_kind, w_len;
  logic [SUM_W-1:0]    w_end, w_span;
  logic [WIDX_W-1:0]   w_extra;
  logic                w_words_left, w_check;

  function automatic logic [7:0] byte_at(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // Where to go once the cursor has moved past a NOP or a completed option.
  function automatic state_t advance(input logic [CURSOR_W-1:0] c,
                                     input logic [CURSOR_W-1:0] area);
    state_t s;
    if (c == area)
      s = S_DONE;
    else if (c[1:0] == 2'd0)
      s = S_FETCH;
    else
      s = S_DECODE;
    return s;
  endfunction

  assign w_pos        = r_cursor[1:0];
  assign w_kind       = byte_at(r_word, w_pos);
  // In GETLEN the length byte is the first byte of the word arriving now.
  assign w_len        = (r_state == S_GETLEN) ? bus.in_data[31:24]
                                              : byte_at(r_word, w_pos + 2'd1);
  assign w_end        = SUM_W'(r_cursor) + SUM_W'(w_len);
  assign w_span       = SUM_W'(w_pos) + SUM_W'(w_len) - SUM_W'(1);
  assign w_extra      = WIDX_W'(w_span >> 2);
  assign w_words_left = (r_widx != r_area_words);

  always_comb begin
    w_state_nxt      = r_state;
    w_word_nxt       = r_word;
    w_next_nxt       = r_next;
    w_have_next_nxt  = r_have_next;
    w_widx_nxt       = r_widx;
    w_area_words_nxt = r_area_words;
    w_area_bytes_nxt = r_area_bytes;
    w_cursor_nxt     = r_cursor;
    w_pos_nxt        = r_pos;
    w_len_nxt        = r_len;
    w_rem_nxt        = r_rem;
    w_err_nxt        = r_err;
    w_err_code_nxt   = r_err_code;
    w_opts_av_nxt    = r_opts_av;
    w_in_ready       = 1'b0;
    w_opt_rst        = 1'b0;
    w_opt_vld        = 1'b0;
    w_opt_pos        = 2'd0;
    w_opt_data       = 32'h0;
    w_check          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_err_nxt        = (data_off < 4'd5);
          w_err_code_nxt   = (data_off < 4'd5) ? c_err_doff : c_err_none;
          w_opts_av_nxt    = 9'h0;
          w_cursor_nxt     = '0;
          w_widx_nxt       = '0;
          w_have_next_nxt  = 1'b0;
          w_area_words_nxt = WIDX_W'(data_off - 4'd5);
          w_area_bytes_nxt = CURSOR_W'({data_off - 4'd5, 2'b00});
          w_state_nxt      = (data_off <= 4'd5) ? S_DONE : S_FETCH;
        end
      end

      S_FETCH: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_word_nxt  = bus.in_data;
          w_widx_nxt  = r_widx + WIDX_W'(1);
          w_state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        if (w_kind == 8'd0) begin
          w_state_nxt = S_DRAIN;
        end else if (w_kind == 8'd1) begin
          w_cursor_nxt = r_cursor + CURSOR_W'(1);
          w_state_nxt  = advance(w_cursor_nxt, r_area_bytes);
        end else if (w_pos == 2'd3) begin
          // Length byte lives in the next word; none left means it lies
          // outside the option area.
          if (w_words_left) begin
            w_state_nxt = S_GETLEN;
          end else begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = c_err_ovr;
            w_state_nxt    = S_DRAIN;
          end
        end else begin
          w_check = 1'b1;
        end
      end

      S_GETLEN: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_next_nxt      = bus.in_data;
          w_have_next_nxt = 1'b1;
          w_widx_nxt      = r_widx + WIDX_W'(1);
          w_check         = 1'b1;
        end
      end

      S_PRST: begin
        w_opt_rst   = 1'b1;
        w_state_nxt = S_FEED;
      end

      S_FEED: begin
        w_opt_vld   = 1'b1;
        w_opt_pos   = r_pos;
        w_opt_data  = r_word;
        w_state_nxt = (r_rem == '0) ? S_EVAL : S_CONT;
      end

      S_CONT: begin
        w_opt_pos = r_pos;
        if (r_have_next) begin
          // The prefetched word goes first and needs no handshake.
          w_opt_vld       = 1'b1;
          w_opt_data      = r_next;
          w_word_nxt      = r_next;
          w_have_next_nxt = 1'b0;
          w_rem_nxt       = r_rem - WIDX_W'(1);
          if (r_rem == WIDX_W'(1))
            w_state_nxt = S_EVAL;
        end else begin
          w_in_ready = 1'b1;
          if (bus.in_valid) begin
            w_opt_vld  = 1'b1;
            w_opt_data = bus.in_data;
            w_word_nxt = bus.in_data;
            w_widx_nxt = r_widx + WIDX_W'(1);
            w_rem_nxt  = r_rem - WIDX_W'(1);
            if (r_rem == WIDX_W'(1))
              w_state_nxt = S_EVAL;
          end
        end
      end

      S_EVAL: begin
        w_opts_av_nxt = r_opts_av | bus.opt_av_in;
        if (|bus.opt_err_in) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = c_err_par;
          w_state_nxt    = S_DRAIN;
        end else begin
          // Lengths have already been bounded by the area size.
          w_cursor_nxt = r_cursor + CURSOR_W'(r_len);
          w_state_nxt  = advance(w_cursor_nxt, r_area_bytes);
        end
      end

      S_DRAIN: begin
        if (w_words_left) begin
          w_in_ready = 1'b1;
          if (bus.in_valid)
            w_widx_nxt = r_widx + WIDX_W'(1);
        end else begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Length validation shared by the in-word and next-word length paths.
    if (w_check) begin
      if (w_len < 8'd2) begin
        w_err_nxt      = 1'b1;
        w_err_code_nxt = c_err_len;
        w_state_nxt    = S_DRAIN;
      end else if (w_end > SUM_W'(r_area_bytes)) begin
        w_err_nxt      = 1'b1;
        w_err_code_nxt = c_err_ovr;
        w_state_nxt    = S_DRAIN;
      end else begin
        w_len_nxt   = w_len;
        w_pos_nxt   = w_pos;
        w_rem_nxt   = w_extra;
        w_state_nxt = S_PRST;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_word       <= 32'h0;
      r_next       <= 32'h0;
      r_have_next  <= 1'b0;
      r_widx       <= '0;
      r_area_words <= '0;
      r_area_bytes <= '0;
      r_cursor     <= '0;
      r_pos        <= 2'd0;
      r_len        <= 8'd0;
      r_rem        <= '0;
      r_err        <= 1'b0;
      r_err_code   <= 3'd0;
      r_opts_av    <= 9'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_word       <= w_word_nxt;
      r_next       <= w_next_nxt;
      r_have_next  <= w_have_next_nxt;
      r_widx       <= w_widx_nxt;
      r_area_words <= w_area_words_nxt;
      r_area_bytes <= w_area_bytes_nxt;
      r_cursor     <= w_cursor_nxt;
      r_pos        <= w_pos_nxt;
      r_len        <= w_len_nxt;
      r_rem        <= w_rem_nxt;
      r_err        <= w_err_nxt;
      r_err_code   <= w_err_code_nxt;
      r_opts_av    <= w_opts_av_nxt;
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.opt_rst  = w_opt_rst;
  assign bus.opt_vld  = w_opt_vld;
  assign bus.opt_pos  = {1'b0, w_opt_pos};
  assign bus.opt_data = w_opt_data;

  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done     = (r_state == S_DONE);
  assign err      = r_err;
  assign err_code = r_err_code;
  assign opts_av  = r_opts_av;

`ifdef TCP_OPT_SEQ_STATS_EN
  logic [5:0] r_nop_cnt;
  logic [3:0] r_opt_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_nop_cnt <= 6'd0;
      r_opt_cnt <= 4'd0;
    end else if ((r_state == S_IDLE) && start) begin
      r_nop_cnt <= 6'd0;
      r_opt_cnt <= 4'd0;
    end else begin
      if ((r_state == S_DECODE) && (w_kind == 8'd1) && (r_nop_cnt != 6'h3F))
        r_nop_cnt <= r_nop_cnt + 6'd1;
      if ((r_state == S_PRST) && (r_opt_cnt != 4'hF))
        r_opt_cnt <= r_opt_cnt + 4'd1;
    end
  end

  assign nop_cnt = r_nop_cnt;
  assign opt_cnt = r_opt_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tcp_option_sequencer.sv
// ============================================================================
// Module   : tb_tcp_option_sequencer
// Purpose  : Self-checking bench for tcp_option_sequencer. A byte-level walk
//            of each option area predicts the parser feed, opts_av and error
//            outcome; a small parser stand-in answers option_av/option_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tcp_option_sequencer;

  localparam int ERR_KIND = 7;  // kind the parser stand-in flags as erroneous

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] data_off = 4'd0;
  logic       busy, done, err;
  logic [2:0] err_code;
  logic [8:0] opts_av;
`ifdef TCP_OPT_SEQ_STATS_EN
  logic [5:0] nop_cnt;
  logic [3:0] opt_cnt;
`endif

  tcp_option_sequencer_if bus ();

  tcp_option_sequencer #(.MAX_WORDS(10), .CURSOR_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_off (data_off),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .opts_av  (opts_av)
`ifdef TCP_OPT_SEQ_STATS_EN
    ,
    .nop_cnt  (nop_cnt),
    .opt_cnt  (opt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] src_q[$];
  int          valid_pct = 100;
  int          words_acc = 0;
  int          ready_cnt = 0;
  logic [35:0] obs_log[$];
  logic [35:0] exp_log[$];
  logic        p_first = 1'b0;
  logic [7:0]  area_b [0:63];
  logic [8:0]  exp_av;
  int          exp_code;
  int          exp_words;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] word_of(input int w);
    return {area_b[4*w], area_b[4*w+1], area_b[4*w+2], area_b[4*w+3]};
  endfunction

  task automatic set_word(input int w, input logic [31:0] v);
    {area_b[4*w], area_b[4*w+1], area_b[4*w+2], area_b[4*w+3]} = v;
  endtask

  // Word source: presents the queue head just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (reset && src_q.size() > 0 && int'($urandom_range(0, 99)) < valid_pct) begin
      bus.in_valid = 1'b1;
      bus.in_data  = src_q[0];
    end else begin
      bus.in_valid = 1'b0;
      bus.in_data  = 32'h0;
    end
  end

  // Mid-cycle observer: handshakes, parser feed log, parser stand-in.
  always @(negedge clk) begin
    int p_kind;
    if (bus.in_ready) ready_cnt++;
    if (bus.in_valid && bus.in_ready && src_q.size() > 0) begin
      void'(src_q.pop_front());
      words_acc++;
    end
    if (bus.opt_rst) begin
      obs_log.push_back({1'b1, 35'd0});
      p_first        = 1'b1;
      bus.opt_av_in  = 9'h0;
      bus.opt_err_in = 9'h0;
    end
    if (bus.opt_vld) begin
      obs_log.push_back({1'b0, bus.opt_pos, bus.opt_data});
      if (p_first) begin
        p_kind = int'((bus.opt_data >> (24 - 8 * int'(bus.opt_pos))) & 32'hFF);
        bus.opt_av_in  = (p_kind < 9) ? 9'(1 << p_kind) : 9'h0;
        bus.opt_err_in = (p_kind == ERR_KIND) ? 9'(1 << p_kind) : 9'h0;
        p_first = 1'b0;
      end
    end
  end

  // Reference: walk the option bytes and list what the parser must see.
  task automatic model(input int doff);
    int area, c, k, len;
    exp_log.delete();
    exp_av   = 9'h0;
    exp_code = 0;
    if (doff < 5) begin exp_code = 4; exp_words = 0; return; end
    area      = 4 * (doff - 5);
    exp_words = doff - 5;
    c = 0;
    while (c < area) begin
      k = int'(area_b[c]);
      if (k == 0) break;
      if (k == 1) begin c++; continue; end
      if (c + 1 >= area) begin exp_code = 2; break; end
      len = int'(area_b[c+1]);
      if (len < 2) begin exp_code = 1; break; end
      if (c + len > area) begin exp_code = 2; break; end
      exp_log.push_back({1'b1, 35'd0});
      for (int w = c / 4; w <= (c + len - 1) / 4; w++)
        exp_log.push_back({1'b0, 3'(c % 4), word_of(w)});
      if (k < 9) exp_av |= 9'(1 << k);
      if (k == ERR_KIND) begin exp_code = 3; break; end
      c += len;
    end
  endtask

  task automatic run_area(input string name, input int doff);
    int   cyc, area_w, n;
    logic b1;
    model(doff);
    src_q.delete();
    obs_log.delete();
    area_w = (doff > 5) ? doff - 5 : 0;
    for (int w = 0; w < area_w; w++) src_q.push_back(word_of(w));
    words_acc = 0;
    ready_cnt = 0;
    @(posedge clk); #1;
    data_off = 4'(doff);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    b1  = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) b1 = busy;
    end while (!done && cyc < 2000);
    check({name, ":done"}, done, 1);
    if (doff <= 5) begin
      check({name, ":latency"}, cyc, 1);
      check({name, ":ready_cnt"}, ready_cnt, 0);
    end else begin
      check({name, ":busy"}, b1, 1);
    end
    check({name, ":err"}, err, (exp_code != 0));
    check({name, ":err_code"}, err_code, exp_code);
    check({name, ":opts_av"}, opts_av, exp_av);
    check({name, ":words"}, words_acc, exp_words);
    check({name, ":feed_len"}, obs_log.size(), exp_log.size());
    n = (obs_log.size() < exp_log.size()) ? obs_log.size() : exp_log.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s:feed%0d", name, i), obs_log[i], exp_log[i]);
    if (!done) begin
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
    end else begin
      @(negedge clk);
      check({name, ":done_pulse"}, {done, busy}, 2'b00);
    end
  endtask

  task automatic gen_random(input int doff);
    int area, c, rem, r, len;
    area = 4 * (doff - 5);
    for (int i = 0; i < 64; i++) area_b[i] = 8'($urandom);
    c = 0;
    while (c < area) begin
      rem = area - c;
      r   = int'($urandom_range(0, 99));
      if (rem == 1 && r < 40) begin
        area_b[c] = 8'($urandom_range(2, 10));
        break;
      end else if (r < 20 || rem < 2) begin
        area_b[c] = 8'd1;
        c++;
      end else if (r < 25) begin
        area_b[c] = 8'd0;
        break;
      end else if (r < 30) begin
        area_b[c]   = 8'($urandom_range(2, 10));
        area_b[c+1] = 8'($urandom_range(0, 1));
        break;
      end else if (r < 35) begin
        area_b[c]   = 8'($urandom_range(2, 10));
        area_b[c+1] = 8'(rem + int'($urandom_range(1, 10)));
        break;
      end else begin
        len = int'($urandom_range(2, (rem < 12) ? rem : 12));
        area_b[c]   = 8'($urandom_range(2, 10));
        area_b[c+1] = 8'(len);
        c += len;
      end
    end
  endtask

  initial begin
    int cyc;
    logic b_before;
    bus.in_valid   = 1'b0;
    bus.in_data    = 32'h0;
    bus.opt_av_in  = 9'h0;
    bus.opt_err_in = 9'h0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_state",
          {busy, done, err, err_code, opts_av, bus.in_ready, bus.opt_rst,
           bus.opt_vld, bus.opt_pos, bus.opt_data}, 64'h0);
    reset = 1'b1;

    run_area("doff5", 5);
    run_area("doff4", 4);

    set_word(0, 32'h020405B4);
    run_area("mss", 6);

    set_word(0, 32'h0101080A); set_word(1, 32'h11223344); set_word(2, 32'h55667788);
    run_area("nop_ts", 8);

    set_word(0, 32'h01030307); set_word(1, 32'h00000000);
    run_area("ws_eol", 7);

    set_word(0, 32'h0208AABB);
    run_area("overrun", 6);

    set_word(0, 32'h01010102);
    run_area("len_beyond", 6);

    set_word(0, 32'h0301CCDD);
    run_area("bad_len", 6);

    set_word(0, 32'h07040000);
    run_area("parser_err", 6);

    // Option whose length byte sits in the following word.
    set_word(0, 32'h01010104); set_word(1, 32'h05112233);
    run_area("len_next_word", 7);

    // Asynchronous reset while continuation words are outstanding.
    set_word(0, 32'h0101080A); set_word(1, 32'h11223344); set_word(2, 32'h55667788);
    src_q.delete();
    obs_log.delete();
    src_q.push_back(word_of(0));
    @(posedge clk); #1;
    data_off = 4'd8;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (obs_log.size() < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reach_cont", obs_log.size(), 2);
    @(negedge clk);
    b_before = busy;
    check("rst_busy_before", b_before, 1);
    #1 reset = 1'b0;
    #1;
    check("rst_async_outputs",
          {busy, done, err, err_code, opts_av, bus.in_ready, bus.opt_rst,
           bus.opt_vld, bus.opt_pos, bus.opt_data}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    run_area("after_reset", 8);

    valid_pct = 70;
    for (int t = 0; t < 60; t++) begin
      int doff;
      doff = int'($urandom_range(6, 15));
      gen_random(doff);
      run_area($sformatf("rand%0d", t), doff);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tcp_option_sequencer.md
Name: tcp_option_sequencer

Overview:
- Walks the TCP option area word by word and drives the TCP option field parser (output_shift_byte_counter) one option at a time.
- For each option it:
  - finds the option start inside the current 32-bit word;
  - pulses the parser reset and feeds it that word plus any continuation words;
  - skips NOP, stops at EOL, and drains unused words so the stream stays aligned.
- Sits between the TCP header word stream and the option parser in the TCP decoder.

Parameters:
MAX_WORDS, 10, maximum option-area words (data_off 15 - 5)
CURSOR_W, 6, width of byte cursor (covers 0..4*MAX_WORDS)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse: option area begins with next in_data word
data_off  input  4  TCP data offset, sampled on start
in_valid  input  1  in_data valid
in_data  input  32  option-area word; byte 0 = [31:24]
in_ready  output  1  word accepted when in_valid & in_ready
opt_rst  output  1  active-high parser reset, one cycle per dispatched option
opt_vld  output  1  opt_data/opt_pos valid to parser this cycle
opt_pos  output  3  start byte (0..3) of current option in its first word
opt_data  output  32  word presented to parser
opt_av_in  input  9  parser option_av
opt_err_in  input  9  parser option_err
busy  output  1  high from start until done
done  output  1  one-cycle pulse: option area fully consumed
err  output  1  sticky error flag, cleared on start
err_code  output  3  0 none, 1 bad length, 2 overrun, 3 parser error, 4 bad data_off
opts_av  output  9  OR of opt_av_in over all options, valid at done

Behaviour:
- Reset: all outputs 0, state IDLE, cursor 0, word register 0.
- On start: area_bytes = 4*(data_off-5).
  - data_off<5: err=1, err_code=4, done pulse next cycle.
  - data_off==5: done pulse next cycle, no words consumed.
  - Otherwise clear err and opts_av, set busy, go to FETCH.
- start while busy: ignored.
- States:
  - IDLE
  - FETCH: in_ready=1; load word register, increment word index.
  - DECODE: kind = byte cursor[1:0] of word register.
  - GETLEN: fetch next word when the length byte is not in the current word.
  - PRST: opt_rst=1 for one cycle.
  - FEED: opt_vld=1, opt_pos=first-word byte offset, opt_data=word.
  - CONT: fetch + feed continuation words, opt_pos held.
  - DRAIN: consume the remaining words.
  - DONE
- DECODE:
  - kind 0 (EOL) -> DRAIN.
  - kind 1 (NOP) -> cursor+1, no parser activity.
  - else len = following byte.
    - len<2: err_code 1.
    - cursor+len > area_bytes: err_code 2.
    - otherwise -> PRST.
- Word count per option: the parser sees ceil((pos+len)/4) words, one per cycle with no gaps.
- A word that ends one option and starts the next is re-presented to the parser after the next PRST. It is not re-fetched.
- Stalls: if in_valid is low during CONT, opt_vld drops and the parser is held (no opt_rst).
- Cycle after the last word of an option:
  - OR opt_av_in into opts_av;
  - nonzero opt_err_in -> err_code 3.
- Cursor advance:
  - cursor += len;
  - cursor == area_bytes -> DONE;
  - cursor[1:0]==0 with words left -> FETCH;
  - else DECODE.
- Any error: set err, go to DRAIN.
- DRAIN: accept in_valid words until word index == area words, then DONE.
- DONE: done=1 one cycle, busy=0, return to IDLE.
- An async reset mid-operation aborts immediately and returns to IDLE.

Optional Feature:
- TCP_OPT_SEQ_STATS_EN defined adds outputs nop_cnt[5:0] and opt_cnt[3:0]:
  - count NOPs skipped and options dispatched;
  - cleared on start, saturating.
- Undefined: ports absent, no counter logic.

Test Plan:
- data_off=5, start -> done one cycle later, in_ready never high, err=0.
- data_off=6, word 02 04 05 B4 -> opt_rst, opt_vld with opt_pos=0 and data 0x020405B4, opts_av bit2 set, done.
- data_off=8, words 01 01 08 0A / TS / TS -> 2 NOPs skipped, one opt_rst, 3 words fed with opt_pos=2, done after word 3.
- data_off=7, words 01 03 03 07 / 00 00 00 00 -> window-scale fed, EOL hit, second word drained, done, err=0.
- data_off=6, word 02 08 xx xx -> err=1, err_code=2, done.
- Reset asserted in CONT -> all outputs 0 immediately; new start then parses correctly.
